// File: rtl/vdp2_cram_arb.sv
// rtl/vdp2_cram_arb.sv - CRAM port arbiter: display reads over CPU FIFO writes with byte-merge RMW
module vdp2_cram_arb (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FIFO_EMPTY,
  input  logic [35:0] FIFO_Q,
  output logic        FIFO_RDREQ,
  input  logic        DISP_REQ,
  input  logic [10:0] DISP_ADDR,
  output logic [15:0] DISP_Q,
  output logic        DISP_VALID,
  output logic [10:0] RAM_ADDR,
  output logic [15:0] RAM_DATA,
  output logic        RAM_WREN,
  input  logic [15:0] RAM_Q,
  output logic        WR_STALL
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_disp_valid;
  logic [15:0] r_merge;
  logic [3:0]  r_starve;

  logic [1:0]  w_be;
  logic [10:0] w_fifo_addr;
  logic [15:0] w_fifo_data;
  logic [15:0] w_merged;
  logic        w_unused_fifo_bits;

  assign w_be               = FIFO_Q[35:34];
  assign w_fifo_addr        = FIFO_Q[26:16];
  assign w_fifo_data        = FIFO_Q[15:0];
  assign w_unused_fifo_bits = ^FIFO_Q[33:27];

  // Enabled bytes come from the CPU entry, the rest from the word read back from CRAM.
  assign w_merged = {w_be[1] ? w_fifo_data[15:8] : r_merge[15:8],
                     w_be[0] ? w_fifo_data[7:0]  : r_merge[7:0]};

  // The RAM returns data one cycle after the address, so display data passes straight through.
  assign DISP_Q     = RAM_Q;
  assign DISP_VALID = r_disp_valid;
  assign WR_STALL   = (r_starve == 4'hF);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and CRAM port drive; display owns the port whenever it asks.
  always_comb begin
    w_next     = r_state;
    RAM_ADDR   = w_fifo_addr;
    RAM_DATA   = w_fifo_data;
    RAM_WREN   = 1'b0;
    FIFO_RDREQ = 1'b0;
    case (r_state)
      IDLE: begin
        if (!DISP_REQ && !FIFO_EMPTY) begin
          case (w_be)
            2'b11: begin
              RAM_WREN   = 1'b1;
              FIFO_RDREQ = 1'b1;
            end
            2'b00:   FIFO_RDREQ = 1'b1;
            default: w_next = RMW_RD;
          endcase
        end
      end
      RMW_RD: w_next = RMW_WR;
      RMW_WR: begin
        if (!DISP_REQ) begin
          w_next   = IDLE;
          RAM_DATA = w_merged;
          if (!FIFO_EMPTY) begin
            RAM_WREN   = 1'b1;
            FIFO_RDREQ = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (DISP_REQ) RAM_ADDR = DISP_ADDR;
    if (RST) begin
      RAM_WREN   = 1'b0;
      FIFO_RDREQ = 1'b0;
    end
  end

  // Display valid is the request delayed to match the RAM read latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_disp_valid <= 1'b0;
    else     r_disp_valid <= DISP_REQ;
  end

  // Capture the old CRAM word during the read half of a partial write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   r_merge <= 16'h0000;
    else if (r_state == RMW_RD) r_merge <= RAM_Q;
  end

  // Count cycles a pending FIFO entry goes unserviced, saturating at 15.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         r_starve <= 4'h0;
    else if (FIFO_EMPTY || FIFO_RDREQ) r_starve <= 4'h0;
    else if (r_starve != 4'hF)       r_starve <= r_starve + 4'h1;
  end

endmodule

// File: tb/tb_vdp2_cram_arb.sv
// tb/tb_vdp2_cram_arb.sv - directed table and sequence checks for vdp2_cram_arb
module tb_vdp2_cram_arb;

  logic        CLK;
  logic        RST;
  logic        FIFO_EMPTY;
  logic [35:0] FIFO_Q;
  logic        FIFO_RDREQ;
  logic        DISP_REQ;
  logic [10:0] DISP_ADDR;
  logic [15:0] DISP_Q;
  logic        DISP_VALID;
  logic [10:0] RAM_ADDR;
  logic [15:0] RAM_DATA;
  logic        RAM_WREN;
  logic [15:0] RAM_Q;
  logic        WR_STALL;

  logic [15:0] mem [2048];
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [15:0] pre_data;
  int          wr_cnt;
  int          pop_cnt;
  int          n_tests;
  int          n_fail;

  vdp2_cram_arb dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_Q     (FIFO_Q),
    .FIFO_RDREQ (FIFO_RDREQ),
    .DISP_REQ   (DISP_REQ),
    .DISP_ADDR  (DISP_ADDR),
    .DISP_Q     (DISP_Q),
    .DISP_VALID (DISP_VALID),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_DATA   (RAM_DATA),
    .RAM_WREN   (RAM_WREN),
    .RAM_Q      (RAM_Q),
    .WR_STALL   (WR_STALL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // CRAM model: registered read, bench preload port, write/pop counters
  always @(posedge CLK) begin
    if (pre_we)        mem[pre_addr] <= pre_data;
    else if (RAM_WREN) mem[RAM_ADDR] <= RAM_DATA;
    RAM_Q <= mem[RAM_ADDR];
    if (RAM_WREN)   wr_cnt  <= wr_cnt + 1;
    if (FIFO_RDREQ) pop_cnt <= pop_cnt + 1;
  end

  typedef struct {
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        fifo_empty;
    logic [35:0] fifo_q;
    logic        chk_addr;
    logic [10:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_wren;
    logic        exp_rdreq;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [35:0] mk(input logic [1:0] be, input logic [10:0] a,
                                     input logic [15:0] d, input logic [6:0] junk);
    return {be, junk, a, d};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [15:0] d);
    @(negedge CLK);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST        = 1'b1;
    FIFO_EMPTY = 1'b1;
    DISP_REQ   = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Partial write of entry at 0x020 over an old word of 0x1234.
  task automatic do_rmw(input logic [1:0] be, input logic [15:0] expv, input string nm);
    int w0;
    int p0;
    RST = 1'b1;
    preload(11'h020, 16'h1234);
    @(negedge CLK);
    RST        = 1'b0;
    DISP_REQ   = 1'b0;
    FIFO_EMPTY = 1'b0;
    FIFO_Q     = mk(be, 11'h020, 16'hFF99, 7'h00);
    w0 = wr_cnt;
    p0 = pop_cnt;
    #1;
    chk({nm, "_c1_addr"}, 16'(RAM_ADDR), 16'h0020);
    chk({nm, "_c1_wren"}, 16'(RAM_WREN), 16'h0);
    chk({nm, "_c1_rdreq"}, 16'(FIFO_RDREQ), 16'h0);
    @(negedge CLK); #1;
    chk({nm, "_c2_wren"}, 16'(RAM_WREN), 16'h0);
    chk({nm, "_c2_rdreq"}, 16'(FIFO_RDREQ), 16'h0);
    @(negedge CLK); #1;
    chk({nm, "_c3_wren"}, 16'(RAM_WREN), 16'h1);
    chk({nm, "_c3_addr"}, 16'(RAM_ADDR), 16'h0020);
    chk({nm, "_c3_data"}, RAM_DATA, expv);
    chk({nm, "_c3_rdreq"}, 16'(FIFO_RDREQ), 16'h1);
    @(negedge CLK);
    FIFO_EMPTY = 1'b1;
    #1;
    chk({nm, "_mem"}, mem[11'h020], expv);
    chk({nm, "_pops"}, 16'(pop_cnt - p0), 16'd1);
    chk({nm, "_writes"}, 16'(wr_cnt - w0), 16'd1);
  endtask

  initial begin
    int w0;
    int p0;
    n_tests = 0;
    n_fail  = 0;
    wr_cnt  = 0;
    pop_cnt = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    RST = 1'b1; FIFO_EMPTY = 1'b0; DISP_REQ = 1'b1; DISP_ADDR = 11'h001;
    FIFO_Q = mk(2'b11, 11'h010, 16'hABCD, 7'h00);

    //            dreq  daddr    empty fifo_q                                     chka exp_addr exp_data wren rdreq
    vecs[0] = '{1'b0, 11'h000, 1'b0, mk(2'b11, 11'h010, 16'hABCD, 7'h00), 1'b1, 11'h010, 16'hABCD, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 11'h000, 1'b0, mk(2'b00, 11'h011, 16'h1111, 7'h00), 1'b0, 11'h000, 16'h0000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 11'h155, 1'b0, mk(2'b11, 11'h010, 16'hABCD, 7'h00), 1'b1, 11'h155, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 11'h000, 1'b1, mk(2'b11, 11'h012, 16'h2222, 7'h00), 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 11'h7FF, 1'b1, mk(2'b11, 11'h013, 16'h3333, 7'h00), 1'b1, 11'h7FF, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 11'h000, 1'b0, mk(2'b01, 11'h022, 16'h4444, 7'h00), 1'b1, 11'h022, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 11'h001, 1'b0, mk(2'b10, 11'h023, 16'h5555, 7'h00), 1'b1, 11'h001, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 11'h000, 1'b0, mk(2'b11, 11'h7FF, 16'h0000, 7'h7F), 1'b1, 11'h7FF, 16'h0000, 1'b1, 1'b1};

    // reset state with a writable entry and a display request pending
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_wren", 16'(RAM_WREN), 16'h0);
    chk("rst_rdreq", 16'(FIFO_RDREQ), 16'h0);
    chk("rst_dvalid", 16'(DISP_VALID), 16'h0);
    chk("rst_stall", 16'(WR_STALL), 16'h0);

    // single-cycle decisions from IDLE
    for (int i = 0; i < 8; i++) begin
      do_reset();
      DISP_REQ   = vecs[i].disp_req;
      DISP_ADDR  = vecs[i].disp_addr;
      FIFO_EMPTY = vecs[i].fifo_empty;
      FIFO_Q     = vecs[i].fifo_q;
      #1;
      if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), 16'(RAM_ADDR), 16'(vecs[i].exp_addr));
      if (vecs[i].exp_wren) chk($sformatf("v%0d_data", i), RAM_DATA, vecs[i].exp_data);
      chk($sformatf("v%0d_wren", i), 16'(RAM_WREN), 16'(vecs[i].exp_wren));
      chk($sformatf("v%0d_rdreq", i), 16'(FIFO_RDREQ), 16'(vecs[i].exp_rdreq));
      @(negedge CLK); #1;
      chk($sformatf("v%0d_dvalid", i), 16'(DISP_VALID), 16'(vecs[i].disp_req));
    end

    // partial writes, low and high byte
    do_rmw(2'b01, 16'h1299, "rmw_lo");
    do_rmw(2'b10, 16'hFF34, "rmw_hi");

    // display holds off the write phase of an RMW for 5 cycles
    RST = 1'b1;
    preload(11'h020, 16'h1234);
    for (int k = 0; k < 5; k++) preload(11'h100 + 11'(k), 16'hA000 + 16'(k));
    @(negedge CLK);
    RST = 1'b0; DISP_REQ = 1'b0; FIFO_EMPTY = 1'b0;
    FIFO_Q = mk(2'b01, 11'h020, 16'hFF99, 7'h00);
    w0 = wr_cnt; p0 = pop_cnt;
    @(negedge CLK);
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      DISP_REQ  = (k < 5);
      DISP_ADDR = 11'h100 + 11'(k);
      #1;
      if (k < 5) begin
        chk($sformatf("hold%0d_wren", k), 16'(RAM_WREN), 16'h0);
        chk($sformatf("hold%0d_addr", k), 16'(RAM_ADDR), 16'h0100 + 16'(k));
        chk($sformatf("hold%0d_rdreq", k), 16'(FIFO_RDREQ), 16'h0);
      end else begin
        chk("hold_commit_wren", 16'(RAM_WREN), 16'h1);
        chk("hold_commit_data", RAM_DATA, 16'h1299);
      end
      chk($sformatf("hold%0d_dvalid", k), 16'(DISP_VALID), (k > 0) ? 16'h1 : 16'h0);
      if (k > 0) chk($sformatf("hold%0d_dq", k), DISP_Q, 16'hA000 + 16'(k - 1));
    end
    @(negedge CLK);
    FIFO_EMPTY = 1'b1;
    #1;
    chk("hold_pops", 16'(pop_cnt - p0), 16'd1);
    chk("hold_writes", 16'(wr_cnt - w0), 16'd1);
    chk("hold_mem", mem[11'h020], 16'h1299);

    // starvation by continuous display traffic
    do_reset();
    FIFO_EMPTY = 1'b0;
    FIFO_Q = mk(2'b11, 11'h030, 16'h7777, 7'h00);
    DISP_REQ = 1'b1; DISP_ADDR = 11'h005;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      chk($sformatf("starve%0d_wren", i), 16'(RAM_WREN), 16'h0);
      chk($sformatf("starve%0d_stall", i), 16'(WR_STALL), (i >= 15) ? 16'h1 : 16'h0);
    end
    @(negedge CLK);
    DISP_REQ = 1'b0;
    #1;
    chk("starve_commit_wren", 16'(RAM_WREN), 16'h1);
    chk("starve_commit_rdreq", 16'(FIFO_RDREQ), 16'h1);
    chk("starve_commit_stall", 16'(WR_STALL), 16'h1);
    @(negedge CLK); #1;
    chk("starve_after_stall", 16'(WR_STALL), 16'h0);
    FIFO_EMPTY = 1'b1;

    // reset in RMW_WR abandons the write, then the entry is redone
    RST = 1'b1;
    preload(11'h020, 16'h1234);
    @(negedge CLK);
    RST = 1'b0; DISP_REQ = 1'b0; FIFO_EMPTY = 1'b0;
    FIFO_Q = mk(2'b01, 11'h020, 16'hFF99, 7'h00);
    @(negedge CLK);
    DISP_REQ = 1'b1; DISP_ADDR = 11'h100;
    @(negedge CLK);
    DISP_REQ = 1'b0;
    RST = 1'b1;
    w0 = wr_cnt; p0 = pop_cnt;
    #1;
    chk("rstrmw_wren", 16'(RAM_WREN), 16'h0);
    chk("rstrmw_rdreq", 16'(FIFO_RDREQ), 16'h0);
    chk("rstrmw_dvalid", 16'(DISP_VALID), 16'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rstrmw_no_write", 16'(wr_cnt - w0), 16'd0);
    chk("rstrmw_no_pop", 16'(pop_cnt - p0), 16'd0);
    chk("rstrmw_mem_kept", mem[11'h020], 16'h1234);
    chk("redo_c1_wren", 16'(RAM_WREN), 16'h0);
    chk("redo_c1_addr", 16'(RAM_ADDR), 16'h0020);
    @(negedge CLK); #1;
    chk("redo_c2_wren", 16'(RAM_WREN), 16'h0);
    @(negedge CLK); #1;
    chk("redo_c3_wren", 16'(RAM_WREN), 16'h1);
    chk("redo_c3_data", RAM_DATA, 16'h1299);
    chk("redo_c3_rdreq", 16'(FIFO_RDREQ), 16'h1);
    @(negedge CLK);
    FIFO_EMPTY = 1'b1;
    #1;
    chk("redo_mem", mem[11'h020], 16'h1299);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
